// File: rtl/fifo_stream_reader_pkg.sv
// Shared types and constants for the FIFO stream reader and its output buffer.
package fifo_stream_reader_pkg;

  typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} rd_state_t;

  localparam int BUF_DEPTH = 2;

  // Next occupancy of the output buffer; saturates so a stray push/pop cannot wrap it.
  function automatic logic [1:0] cnt_next(input logic [1:0] cnt,
                                          input logic       push,
                                          input logic       pop);
    logic [1:0] n;
    n = cnt;
    if (push && !pop && cnt != 2'(BUF_DEPTH)) begin
      n = cnt + 2'd1;
    end else if (pop && !push && cnt != 2'd0) begin
      n = cnt - 2'd1;
    end
    return n;
  endfunction

endpackage

// File: rtl/fifo_stream_reader_skid.sv
// Two-entry in-order output buffer; entry 0 is always the head presented downstream.
module fifo_stream_reader_skid
  import fifo_stream_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] head_data_o,
  output logic [1:0]            buf_cnt_o
);

  logic [DATA_WIDTH-1:0] ent0_q, ent0_d;
  logic [DATA_WIDTH-1:0] ent1_q, ent1_d;
  logic [1:0]            cnt_q, cnt_d;

  always_comb begin
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    unique case ({push_i, pop_i})
      2'b10: begin
        if (cnt_q == 2'd0) begin
          ent0_d = push_data_i;
        end else if (cnt_q == 2'd1) begin
          ent1_d = push_data_i;
        end
      end
      2'b01: begin
        ent0_d = ent1_q;
      end
      2'b11: begin
        // Capture and pop together: the head advances and the new word joins the tail.
        if (cnt_q == 2'd1) begin
          ent0_d = push_data_i;
        end else begin
          ent0_d = ent1_q;
          ent1_d = push_data_i;
        end
      end
      default: ;
    endcase
    cnt_d = cnt_next(cnt_q, push_i, pop_i);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      ent0_q <= '0;
      ent1_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      ent0_q <= ent0_d;
      ent1_q <= ent1_d;
      cnt_q  <= cnt_d;
    end
  end

  assign head_data_o = ent0_q;
  assign buf_cnt_o   = cnt_q;

endmodule

// File: rtl/fifo_stream_reader.sv
// Read-side master for a 1-cycle-latency FIFO, re-presenting its data as a valid/ready stream.
// Optional beat counter port enabled by defining FIFO_STREAM_READER_STATS_EN.
module fifo_stream_reader
  import fifo_stream_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  busy
`ifdef FIFO_STREAM_READER_STATS_EN
  ,
  output logic [31:0]           beat_count
`endif
);

  rd_state_t  state_q;
  logic       busy_q;
  logic       inflight_q;
  logic [1:0] buf_cnt;
  logic       pop;
  logic [2:0] occ_after_pop;

  assign m_valid = (buf_cnt != 2'd0);
  assign pop     = m_valid & m_ready;

  // Entries that will be held or still landing once this cycle's beat leaves.
  assign occ_after_pop = {1'b0, buf_cnt} + {2'b00, inflight_q} - {2'b00, pop};

  assign fifo_rd_en = reset_n & enable & ~fifo_empty & (state_q != DRAIN)
                    & (occ_after_pop < 3'(BUF_DEPTH));

  fifo_stream_reader_skid #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid (
    .clk_i       (clk),
    .rst_n_i     (reset_n),
    .push_i      (inflight_q),
    .push_data_i (fifo_rd_data),
    .pop_i       (pop),
    .head_data_o (m_data),
    .buf_cnt_o   (buf_cnt)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= fifo_rd_en;
      unique case (state_q)
        IDLE: begin
          if (enable && !fifo_empty) begin
            state_q <= ACTIVE;
            busy_q  <= 1'b1;
          end
        end
        ACTIVE: begin
          if (!enable) begin
            if (buf_cnt != 2'd0 || inflight_q) begin
              state_q <= DRAIN;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
        DRAIN: begin
          if (enable) begin
            state_q <= ACTIVE;
          end else if (buf_cnt == 2'd0 && !inflight_q) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;

`ifdef FIFO_STREAM_READER_STATS_EN
  logic [31:0] beat_cnt_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      beat_cnt_q <= 32'd0;
    end else if (pop) begin
      beat_cnt_q <= beat_cnt_q + 32'd1;
    end
  end

  assign beat_count = beat_cnt_q;
`endif

endmodule

// File: doc/fifo_stream_reader.md
# fifo_stream_reader

Read-side master for the team's `fifo` block. It owns the FIFO's `rd_en` and captures `rd_data`, which is registered with one-cycle latency. It re-presents the data as a valid/ready stream to a downstream consumer. A 2-entry output buffer hides the FIFO read latency, so it sustains one beat per cycle under continuous `m_ready`. Its purpose is to let consumers drain a FIFO without tracking `empty` or the read latency themselves.

## Interface
Parameters:
- `DATA_WIDTH`, default 32: width of FIFO data and of the stream data.

Ports:
- `clk`  in  1  single clock; all logic is rising-edge.
- `reset_n`  in  1  reset, synchronous and active-low, sampled on `clk`.
- `enable`  in  1  allows new FIFO reads; low means stop prefetching and flush what is already in flight.
- `fifo_empty`  in  1  `empty` flag of the FIFO.
- `fifo_rd_data`  in  DATA_WIDTH  FIFO read data, valid the cycle after `fifo_rd_en`.
- `fifo_rd_en`  out  1  FIFO read strobe.
- `m_valid`  out  1  stream data valid.
- `m_ready`  in  1  consumer accepts the beat.
- `m_data`  out  DATA_WIDTH  stream data.
- `busy`  out  1  high when state is not IDLE.
- `beat_count`  out  32  beats delivered. Present only with `FIFO_STREAM_READER_STATS_EN`.

## Operation
- Tracked quantities:
  - `buf_cnt` (0..2) is the number of entries held in the output buffer.
  - `inflight` (0..1) is a read issued last cycle that has not yet landed.
- Read issue: `fifo_rd_en = enable & ~fifo_empty & (buf_cnt + inflight - pop < 2)`, where `pop = m_valid & m_ready`.
  - It is combinational from registered state plus `fifo_empty`, `enable` and `m_ready`.
  - `fifo_rd_en` is never asserted while `fifo_empty` is high.
- Capture: when `inflight` is 1, `fifo_rd_data` is written into the buffer tail at that edge. `inflight` then follows `fifo_rd_en` of the current cycle.
- Output:
  - `m_data` is the buffer head and `m_valid = (buf_cnt != 0)`.
  - `m_data` and `m_valid` are held stable while `m_valid & ~m_ready`.
- Ordering: beats leave in FIFO read order. There is no drop and no duplication.
- Simultaneous capture and pop in one cycle: `buf_cnt` is unchanged and the head advances.
- State machine (`busy = state != IDLE`):
  - IDLE:
    - Goes to ACTIVE when `enable & ~fifo_empty`.
  - ACTIVE:
    - Goes to DRAIN when `~enable` and `buf_cnt + inflight != 0`.
    - Goes to IDLE when `~enable` and all of it is empty.
  - DRAIN:
    - No reads are issued.
    - Goes to IDLE once `buf_cnt == 0` and `inflight == 0`.
    - Goes back to ACTIVE if `enable` returns before that.
- Reset mid-operation:
  - The buffer and any in-flight read are discarded. A read launched in the cycle before reset is lost; the caller owns that case.
  - Every output takes its reset value on the next edge.

## Timing
- Reset values:
  - `fifo_rd_en` = 0, since `inflight` = 0 and `enable` gating applies; the registered state is IDLE.
  - `m_valid` = 0, `m_data` = 0, `busy` = 0.
  - `beat_count` = 0.
- Latency: `fifo_rd_en` high in cycle N gives data captured at the end of N+1, with `m_valid` high in N+2.
- First beat: if `fifo_empty` falls in cycle N with the buffer empty, `m_valid` rises in cycle N+2.
- Throughput: 1 beat/cycle sustained while the FIFO is non-empty and `m_ready` = 1.
- Backpressure: when `m_ready` is low, at most 2 entries are buffered and `fifo_rd_en` drops. The block never overflows its buffer.
- `m_ready` may be high while `m_valid` is low. No beat is transferred in that case.

## Configuration
- `FIFO_STREAM_READER_STATS_EN` defined:
  - The `beat_count` port exists.
  - It increments by 1 on every `m_valid & m_ready`.
  - It wraps modulo 2^32 and clears on reset.
- Not defined: the port and its counter are absent, with no other behavioural change.

## Structure
- Package `fifo_stream_reader_pkg` contains:
  - `typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} rd_state_t`
  - `localparam int BUF_DEPTH = 2`
- Sub-module `fifo_stream_reader_skid` is the 2-entry output buffer.
  - Its ports are push and data in, pop, head data, and a count (`buf_cnt`).
  - The top level holds the FSM, the `inflight` flag, the issue logic and the stats counter.

## Test plan
- Reset mid-stream: assert `reset_n` = 0 with 2 entries buffered.
  - The next edge gives `m_valid` = 0, `fifo_rd_en` = 0, `busy` = 0, and `beat_count` = 0 when the macro is defined.
- Latency: write 4 words into the FIFO, then `enable` = 1 with `m_ready` = 1.
  - `m_valid` rises 2 cycles after the first `fifo_rd_en`.
  - The 4 beats come out back-to-back in write order.
- Backpressure: hold `m_ready` = 0 with 8 words in the FIFO.
  - Exactly 2 reads are issued, then `fifo_rd_en` stays 0.
  - Raising `m_ready` drains all 8 words in order with no gaps after the first.
- Disable mid-stream: drop `enable` with 1 read in flight and 1 entry buffered.
  - State goes to DRAIN, no further `fifo_rd_en`, 2 beats are delivered, then IDLE.
- Empty boundary: a FIFO holding 1 word gives 1 read.
  - `fifo_rd_en` stays 0 while `fifo_empty` = 1.
  - A word written later is read within 1 cycle of `fifo_empty` falling.
- Stats: with `FIFO_STREAM_READER_STATS_EN` defined, stream 20 words. `beat_count` = 20 (0x14), and it stays 20 through idle cycles.
